// File: rtl/timer_regs_pkg.sv
// rtl/timer_regs_pkg.sv - interval timer register map, control bits and master FSM states
package timer_regs_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, WR_STOP,
    SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP
  } state_t;

  function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                            input logic start, input logic stop);
    logic [15:0] w;
    w             = '0;
    w[CTRL_ITO]   = ito;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/avmm_single_master.sv
// rtl/avmm_single_master.sv - registered Avalon-MM drive, one read or write command per cycle
module avmm_single_master #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write_n,
  output logic [DATA_W-1:0] writedata
);

  // Idle cycles park the bus at its reset values so nothing stale is presented.
  always_ff @(posedge clk) begin
    if (reset || !cmd_valid) begin
      address    <= '0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= '0;
    end else begin
      address    <= cmd_address;
      chipselect <= 1'b1;
      write_n    <= ~cmd_write;
      writedata  <= cmd_write ? cmd_writedata : '0;
    end
  end

endmodule

// File: rtl/timer_ctrl_master.sv
// rtl/timer_ctrl_master.sv - programs, services and snapshots one interval timer over Avalon-MM
module timer_ctrl_master
  import timer_regs_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  input  logic              snap_req,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              busy,
  output logic [2:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              irq
);

  state_t            state, nxt;
  logic [15:0]       period_hi_q;
  logic              cont_q;
  logic              snap_pend;
  logic [15:0]       snap_lo;
  logic [31:0]       snap_q;
  logic              cmd_valid, cmd_write;
  logic [2:0]        cmd_address;
  logic [DATA_W-1:0] cmd_writedata;

  always_comb begin
    nxt = state;
    case (state)
      IDLE, RUN: begin
        if (cfg_start)                                nxt = WR_PL;
        else if (cfg_stop)                            nxt = WR_STOP;
        else if (state == RUN && irq)                 nxt = CLR_ST;
        else if (snap_req || (state == RUN && snap_pend)) nxt = SNAP_W;
      end
      WR_PL:    nxt = WR_PH;
      WR_PH:    nxt = WR_CTRL;
      WR_CTRL:  nxt = RUN;
      CLR_ST:   nxt = RUN;
      WR_STOP:  nxt = IDLE;
      SNAP_W:   nxt = SNAP_RL;
      SNAP_RL:  nxt = SNAP_RH;
      SNAP_RH:  nxt = SNAP_CAP;
      SNAP_CAP: nxt = RUN;
      default:  nxt = IDLE;
    endcase
  end

  // The bus register loads on the same edge the FSM enters a state, so decode from nxt.
  always_comb begin
    cmd_valid     = 1'b1;
    cmd_write     = 1'b1;
    cmd_address   = ADDR_STATUS;
    cmd_writedata = '0;
    case (nxt)
      WR_PL: begin
        cmd_address   = ADDR_PERIODL;
        cmd_writedata = cfg_period[15:0];
      end
      WR_PH: begin
        cmd_address   = ADDR_PERIODH;
        cmd_writedata = period_hi_q;
      end
      WR_CTRL: begin
        cmd_address   = ADDR_CONTROL;
        cmd_writedata = ctrl_word(1'b1, cont_q, 1'b1, 1'b0);
      end
      WR_STOP: begin
        cmd_address   = ADDR_CONTROL;
        cmd_writedata = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
      end
      CLR_ST:  cmd_address = ADDR_STATUS;
      SNAP_W:  cmd_address = ADDR_SNAPL;
      SNAP_RL: begin
        cmd_address = ADDR_SNAPL;
        cmd_write   = 1'b0;
      end
      SNAP_RH: begin
        cmd_address = ADDR_SNAPH;
        cmd_write   = 1'b0;
      end
      default: cmd_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      period_hi_q <= '0;
      cont_q      <= 1'b0;
      snap_pend   <= 1'b0;
      snap_lo     <= '0;
      snap_q      <= '0;
      tick        <= 1'b0;
      tick_count  <= '0;
      snap_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state      <= nxt;
      snap_pend  <= (snap_pend || snap_req) && (nxt != SNAP_W);
      tick       <= (nxt == CLR_ST);
      snap_valid <= (nxt == SNAP_CAP);
      busy       <= (nxt != IDLE) && (nxt != RUN);
      if (nxt == WR_PL) begin
        period_hi_q <= cfg_period[31:16];
        cont_q      <= cfg_continuous;
        tick_count  <= '0;
      end
      if (nxt == CLR_ST) tick_count <= tick_count + TICK_W'(1);
      if (state == SNAP_RH) snap_lo <= readdata;
      if (state == SNAP_CAP) snap_q <= snap_value;
    end
  end

  // SNAPH arrives on readdata during SNAP_CAP itself; the register keeps it afterwards.
  assign snap_value = (state == SNAP_CAP) ? {readdata, snap_lo} : snap_q;

  avmm_single_master #(.DATA_W(DATA_W), .ADDR_W(3)) u_bus (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_write     (cmd_write),
    .cmd_address   (cmd_address),
    .cmd_writedata (cmd_writedata),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata)
  );

endmodule

// File: tb/tb_timer_ctrl_master.sv
// tb/tb_timer_ctrl_master.sv - randomized self-checking bench with a behavioural interval timer
module tb_timer_ctrl_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_continuous = 1'b0, snap_req = 1'b0;
  logic [31:0] cfg_period = '0;
  logic [31:0] snap_value;
  logic        snap_valid, tick, busy, chipselect, write_n, irq;
  logic [15:0] tick_count, writedata, readdata;
  logic [2:0]  address;

  int n_checks = 0;
  int n_errors = 0;
  int tick_seen = 0;

  always #5 clk = ~clk;

  timer_ctrl_master #(.DATA_W(16), .TICK_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_period     (cfg_period),
    .cfg_continuous (cfg_continuous),
    .snap_req       (snap_req),
    .snap_value     (snap_value),
    .snap_valid     (snap_valid),
    .tick           (tick),
    .tick_count     (tick_count),
    .busy           (busy),
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .irq            (irq)
  );

  // Interval timer: N-1 period, counts down, reload on zero, registered readdata.
  logic        tmr_clr = 1'b1;
  logic [31:0] t_period = '0, t_cnt = '0, t_snap = '0;
  logic        t_run = 1'b0, t_to = 1'b0, t_cont = 1'b0, t_ito = 1'b0;

  assign irq = t_to & t_ito;

  always @(posedge clk) begin
    if (tick) tick_seen <= tick_seen + 1;
    if (tmr_clr) begin
      t_period <= '0; t_cnt <= '0; t_snap <= '0;
      t_run <= 1'b0; t_to <= 1'b0; t_cont <= 1'b0; t_ito <= 1'b0;
      readdata <= '0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to  <= 1'b1;
          t_cnt <= t_period;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      if (chipselect && !write_n) begin
        case (address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito  <= writedata[0];
            t_cont <= writedata[1];
            if (writedata[2]) begin t_run <= 1'b1; t_cnt <= t_period; end
            if (writedata[3]) t_run <= 1'b0;
          end
          3'd2: begin
            t_period[15:0] <= writedata; t_run <= 1'b0; t_cnt <= {t_period[31:16], writedata};
          end
          3'd3: begin
            t_period[31:16] <= writedata; t_run <= 1'b0; t_cnt <= {writedata, t_period[15:0]};
          end
          3'd4, 3'd5: t_snap <= t_cnt;
          default: ;
        endcase
      end
      if (chipselect && write_n) begin
        case (address)
          3'd0: readdata <= {14'b0, t_run, t_to};
          3'd1: readdata <= {14'b0, t_cont, t_ito};
          3'd2: readdata <= t_period[15:0];
          3'd3: readdata <= t_period[31:16];
          3'd4: readdata <= t_snap[15:0];
          3'd5: readdata <= t_snap[31:16];
          default: readdata <= '0;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bw(input logic cs, input logic wn, input logic [2:0] a,
                                     input logic [15:0] d);
    return {11'b0, cs, wn, a, d};
  endfunction

  // Ticks up to and including relative cycle n after a continuous start at cycle 0.
  function automatic int exp_ticks(input int p, input int n);
    return (n < p + 6) ? 0 : (n - p - 6) / (p + 1) + 1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1; tmr_clr = 1'b1;
    step(1);
    reset = 1'b0; tmr_clr = 1'b0;
    step(1);
  endtask

  task automatic start(input logic [31:0] p, input logic cont);
    cfg_period = p; cfg_continuous = cont; cfg_start = 1'b1;
    step(1);
    cfg_start = 1'b0;
  endtask

  initial begin #5_000_000; $display("FAIL watchdog: no finish"); $fatal(1); end

  initial begin
    int p, n, r, cur, base, lat;
    logic found;
    logic [31:0] pv;

    step(3);
    check("rst_bus", bw(chipselect, write_n, address, writedata), bw(1'b0, 1'b1, 3'd0, 16'h0));
    check("rst_outs", {27'b0, tick, snap_valid, busy, 2'b0}, 32'h0);
    check("rst_tick_count", 32'(tick_count), 32'h0);
    check("rst_snap_value", snap_value, 32'h0);
    reset = 1'b0; tmr_clr = 1'b0;
    step(1);

    // Directed start: period 9, continuous.
    base = tick_seen;
    start(32'h0000_0009, 1'b1);
    check("st_wr_pl", bw(chipselect, write_n, address, writedata), bw(1'b1, 1'b0, 3'd2, 16'h0009));
    step(1);
    check("st_wr_ph", bw(chipselect, write_n, address, writedata), bw(1'b1, 1'b0, 3'd3, 16'h0000));
    step(1);
    check("st_wr_ctrl", bw(chipselect, write_n, address, writedata), bw(1'b1, 1'b0, 3'd1, 16'h0007));
    check("st_busy", 32'(busy), 32'd1);
    step(1);
    check("st_run_bus", bw(chipselect, write_n, address, writedata), bw(1'b0, 1'b1, 3'd0, 16'h0));
    check("st_run_busy", 32'(busy), 32'd0);
    step(51);
    check("cont9_tick_count", 32'(tick_count), 32'(exp_ticks(9, 55)));
    check("cont9_pulses", 32'(tick_seen - base), 32'(exp_ticks(9, 54)));

    // Random continuous periods.
    for (int i = 0; i < 3; i++) begin
      restart();
      p = int'($urandom_range(3, 20));
      n = int'($urandom_range(p + 6, 7 * p + 20));
      base = tick_seen;
      start(32'(p), 1'b1);
      step(n - 1);
      check("rnd_tick_count", 32'(tick_count), 32'(exp_ticks(p, n)));
      check("rnd_pulses", 32'(tick_seen - base), 32'(exp_ticks(p, n - 1)));
    end

    // One-shot: a single timeout, then the timer stays stopped.
    restart();
    p = int'($urandom_range(100, 300));
    base = tick_seen;
    start(32'(p), 1'b0);
    step(p + 39);
    check("oneshot_tick_count", 32'(tick_count), 32'd1);
    check("oneshot_pulses", 32'(tick_seen - base), 32'd1);
    check("oneshot_irq", 32'(irq), 32'd0);
    check("oneshot_stopped", 32'(t_run), 32'd0);

    // Snapshots against a long period: value is the counter during SNAP_W.
    restart();
    pv = 32'h0003_0000;
    start(pv, 1'b1);
    cur = 1;
    for (int i = 0; i < 3; i++) begin
      r = cur + int'($urandom_range(3, 60));
      step(r - cur);
      snap_req = 1'b1;
      step(1);
      snap_req = 1'b0;
      step(2);
      check("snap_rh_bus", bw(chipselect, write_n, address, writedata), bw(1'b1, 1'b1, 3'd5, 16'h0));
      check("snap_early_valid", 32'(snap_valid), 32'd0);
      step(1);
      check("snap_valid", 32'(snap_valid), 32'd1);
      check("snap_value", snap_value, pv - 32'(r) + 32'd3);
      check("snap_range", 32'(snap_value > 0 && snap_value <= pv), 32'd1);
      step(1);
      check("snap_valid_pulse", 32'(snap_valid), 32'd0);
      check("snap_hold", snap_value, pv - 32'(r) + 32'd3);
      cur = r + 5;
    end

    // irq and snap_req together: service first, snapshot follows.
    restart();
    base = tick_seen;
    start(32'h0000_0009, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (irq) begin found = 1'b1; break; end
    end
    check("both_irq_seen", 32'(found), 32'd1);
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
    check("both_tick", 32'(tick), 32'd1);
    check("both_clr_bus", bw(chipselect, write_n, address, writedata), bw(1'b1, 1'b0, 3'd0, 16'h0));
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (snap_valid) begin lat = k; break; end
    end
    check("both_snap_latency", 32'(lat), 32'd5);
    check("both_snap_value", snap_value, 32'd6);
    check("both_pulses", 32'(tick_seen - base), 32'd1);

    // Stop while running.
    restart();
    base = tick_seen;
    start(32'h0000_0009, 1'b1);
    step(3);
    cfg_stop = 1'b1;
    step(1);
    cfg_stop = 1'b0;
    check("stop_bus", bw(chipselect, write_n, address, writedata), bw(1'b1, 1'b0, 3'd1, 16'h0008));
    check("stop_busy", 32'(busy), 32'd1);
    step(1);
    check("stop_status_run", 32'(t_run), 32'd0);
    check("stop_idle_busy", 32'(busy), 32'd0);
    step(40);
    check("stop_no_ticks", 32'(tick_seen - base), 32'd0);
    check("stop_tick_count", 32'(tick_count), 32'd0);

    // Reset in the middle of the programming sequence.
    restart();
    start($urandom, 1'b1);
    step(1);
    check("mid_wr_ph", 32'(address), 32'd3);
    reset = 1'b1;
    step(1);
    check("mid_rst_bus", bw(chipselect, write_n, address, writedata), bw(1'b0, 1'b1, 3'd0, 16'h0));
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tick_count", 32'(tick_count), 32'd0);
    reset = 1'b0;
    step(1);
    check("mid_rst_no_ctrl", bw(chipselect, write_n, address, writedata), bw(1'b0, 1'b1, 3'd0, 16'h0));
    check("mid_rst_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl_master.md
# timer_ctrl_master

Avalon-MM master that drives the 16-bit-data interval timer slave (six-register map, 3-bit word address, registered readdata, no waitrequest) from a simple host-side command interface. On command it programs the 32-bit period and control registers, services timeout interrupts by clearing status, counts ticks, and captures 32-bit counter snapshots on request. It sits between a core's control logic and one timer instance, so firmware-free subsystems can use the timer.

## Interface
- `DATA_W`: 16. Avalon data width; fixed to the timer's width.
- `TICK_W`: 16. Width of the tick counter.
- `clk` in 1: the single clock, shared with the timer.
- `reset` in 1: synchronous, active-high reset.
- `cfg_start` in 1: one-cycle pulse that programs the period and starts the timer.
- `cfg_stop` in 1: one-cycle pulse that stops the timer.
- `cfg_period` in 32: value written to the timer, N−1 for an N-cycle period. Sampled on `cfg_start`.
- `cfg_continuous` in 1: CONT bit. Sampled on `cfg_start`.
- `snap_req` in 1: one-cycle pulse that requests a counter snapshot.
- `snap_value` out 32: last captured snapshot.
- `snap_valid` out 1: one-cycle pulse when `snap_value` updates.
- `tick` out 1: one-cycle pulse per serviced timeout.
- `tick_count` out TICK_W: number of serviced timeouts. Wraps. Cleared on `cfg_start`.
- `busy` out 1: high in any state other than IDLE and RUN.
- `address` out 3, `chipselect` out 1, `write_n` out 1, `writedata` out 16: master outputs to the timer.
- `readdata` in 16, `irq` in 1: from the timer.

## Operation
- Register map (word addresses): 0 STATUS (bit1 RUN, bit0 TO; any write clears TO), 1 CONTROL (bit3 STOP, bit2 START, bit1 CONT, bit0 ITO), 2 PERIODL, 3 PERIODH, 4 SNAPL, 5 SNAPH. Any write to 4 or 5 latches the counter.
- FSM states: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, WR_STOP, SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP.
- IDLE / RUN accept commands, highest priority first:
  - `cfg_start` → WR_PL.
  - `cfg_stop` → WR_STOP.
  - In RUN only: `irq` → CLR_ST.
  - `snap_req` → SNAP_W.
- Commands that arrive in any other state are dropped. `snap_req` is held pending, one deep, until the FSM returns to RUN.
- Writes:
  - WR_PL writes `cfg_period[15:0]` to address 2.
  - WR_PH writes `cfg_period[31:16]` to address 3.
  - WR_CTRL writes `{12'b0,0,1,cfg_continuous,1}` to address 1.
  - This order is mandatory: a period write stops and reloads the timer, so START must come last.
- WR_CTRL → RUN.
- WR_STOP writes `16'h0008` to address 1 → IDLE.
- CLR_ST writes 0 to address 0, pulses `tick`, increments `tick_count` → RUN.
- Snapshot sequence:
  - SNAP_W writes 0 to address 4.
  - SNAP_RL drives address 4 as a read with `chipselect`=1 and `write_n`=1.
  - SNAP_RH drives address 5 and captures `readdata` as the low half.
  - SNAP_CAP captures `readdata` as the high half, drives `snap_value` and `snap_valid` → RUN.
- Every bus state lasts exactly one cycle. Reads have no side effects.
- Reset values (all outputs and state):
  - `chipselect`=0, `write_n`=1, `address`=0, `writedata`=0.
  - `tick`=0, `tick_count`=0, `snap_value`=0, `snap_valid`=0, `busy`=0.
  - State IDLE, pending snapshot cleared.

## Timing
- All bus outputs are registered and change only on `clk`.
- Start: `cfg_start` in cycle 0. Writes occur in cycles 1–3. The timer runs from cycle 4.
- Timeout service: `irq` sampled high in cycle T. The clearing write happens in T+1, `tick` pulses in T+1, and `irq` is low by T+2. One `tick` per timeout.
- A timeout on the same edge as the clearing write is lost inside the timer. This is accepted.
- Snapshot latency is 4 cycles from `snap_req` (RUN) to `snap_valid`. The value is the counter at the SNAP_W edge.
- If `reset` is asserted mid-sequence, the FSM returns to IDLE on the next edge and all outputs take their reset values. The timer's state is not touched.

## Structure
- The shared package `timer_regs_pkg` holds:
  - Address constants ADDR_STATUS … ADDR_SNAPH.
  - Control bit indices CTRL_ITO/CONT/START/STOP.
  - The FSM state enum.
- The single sub-module `avmm_single_master` holds the registered drive of address, chipselect, write_n and writedata, taking one command per cycle. The FSM lives in the top module.

## Test plan
- `cfg_start` with `cfg_period`=32'h0000_0009 and cont=1 → writes 2←0x0009, 3←0x0000, 1←0x0007 in consecutive cycles. The timer `irq` fires every 10 cycles. After 5 irqs, `tick_count`=5.
- `cfg_start` with `cfg_period`=32'h0001_86A0 and cont=0 → one `tick` after 100001 cycles, then no further `irq`. `tick_count` stays 1.
- Timer running with period 0x0003_0000 → `snap_req` → `snap_valid` 4 cycles later, with `snap_value` in (0, 0x0003_0000] and high half read from address 5.
- `irq` and `snap_req` in the same cycle → CLR_ST first, then the snapshot completes. Both `tick` and `snap_valid` occur.
- `cfg_stop` while running → write 1←0x0008. STATUS read back shows RUN=0. No further `tick`.
- `reset` asserted in WR_PH → next cycle `chipselect`=0, `write_n`=1, `busy`=0, `tick_count`=0, state IDLE.
